// File: rtl/imem_program_loader_if.sv
// Program-load bus for imem_program_loader.
//
// Bundles the two data paths that leave or enter the loader:
//   - the upstream word stream: in_valid, in_data (producer to loader)
//     and in_ready (loader to producer).
//   - the instruction-memory write port: imem_we, imem_addr and
//     imem_wdata (loader to memory).
//
// Modports:
//   master : the producer/memory side, used by whatever feeds the loader
//   slave  : the loader itself
interface imem_program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Boot-time program loader.
//
// Receives a program as a valid/ready stream of words, writes each one
// sequentially into instruction memory starting at address 0, and then
// compares a trailing checksum word against the running sum of the
// program words. The CPU start output is raised only after a verified
// load; a failed load parks the loader in ERROR with start low.
//
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   load_req   : one-cycle pulse requesting a new load
//   load_len   : program length in words (trailer excluded), sampled
//                together with load_req
//   bus        : slave side of the word stream and imem write port
//   start      : CPU start, high while a verified program runs
//   busy       : high while loading or checking
//   error      : high after a bad length or a checksum mismatch
//   checksum   : running modulo-2^DATA_WIDTH sum of accepted words
//   word_count : program words accepted in the current load
module imem_program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH:0]   load_len,
    imem_program_loader_if.slave  bus,
    output logic                  start,
    output logic                  busy,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    // Largest legal length: exactly fills the memory.
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH:0]   len_q,    len_d;
    logic [ADDR_WIDTH:0]   cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] sum_q,    sum_d;
    logic                  we_q,     we_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;

    logic                  accept;
    logic                  len_ok;
    logic [ADDR_WIDTH:0]   cnt_inc;

    // Checksum arithmetic deliberately drops the carry out.
    function automatic logic [DATA_WIDTH-1:0] wrap_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    assign bus.in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy         = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign start        = (state_q == S_RUN);
    assign error        = (state_q == S_ERROR);

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign checksum       = sum_q;
    assign word_count     = cnt_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign len_ok  = (load_len != '0) && (load_len <= MAX_LEN);
    assign cnt_inc = cnt_q + (ADDR_WIDTH + 1)'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            // IDLE, RUN and ERROR all react to load_req the same way;
            // counters keep their last values until a valid load begins.
            S_IDLE, S_RUN, S_ERROR: begin
                if (load_req) begin
                    if (len_ok) begin
                        state_d = S_LOAD;
                        len_d   = load_len;
                        cnt_d   = '0;
                        sum_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end

            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = bus.in_data;
                    sum_d   = wrap_add(sum_q, bus.in_data);
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end

            // The trailer is compared, never written to memory.
            S_CHECK: begin
                if (accept) begin
                    state_d = (bus.in_data == sum_q) ? S_RUN : S_ERROR;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader. Expected memory writes
// are queued as words are offered; a negedge monitor pops one entry per
// imem_we pulse. Status outputs are compared directly by the stimulus.
module tb_imem_program_loader;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          load_req;
    logic [AW:0]   load_len;
    logic          start;
    logic          busy;
    logic          error;
    logic [DW-1:0] checksum;
    logic [AW:0]   word_count;

    imem_program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_req   (load_req),
        .load_len   (load_len),
        .bus        (bus.slave),
        .start      (start),
        .busy       (busy),
        .error      (error),
        .checksum   (checksum),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [AW+DW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int mon_tests = 0;
    int mon_fails = 0;

    // Monitor: every write must match the next queued {addr, data}.
    always @(negedge clock) begin
        if (bus.imem_we === 1'b1) begin
            logic [AW+DW-1:0] got;
            logic [AW+DW-1:0] exp;
            got = {bus.imem_addr, bus.imem_wdata};
            mon_tests++;
            if (exp_q.size() == 0) begin
                mon_fails++;
                $display("FAIL unexpected_write got addr=%0d data=%h required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    mon_fails++;
                    $display("FAIL imem_write got addr=%0d data=%h required addr=%0d data=%h",
                             got[AW+DW-1:DW], got[DW-1:0], exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic request(input int len);
        load_req = 1'b1;
        load_len = (AW + 1)'(len);
        tick();
        load_req = 1'b0;
        load_len = '0;
    endtask

    // Offer one word and wait (bounded) until it is accepted. When
    // write_addr >= 0 the word is expected to appear on the memory port.
    task automatic send_word(input logic [DW-1:0] w, input int write_addr);
        int waited;
        if (write_addr >= 0) exp_q.push_back({AW'(write_addr), w});
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            fails++;
            tests++;
            $display("FAIL accept_timeout got in_ready=%b required 1", bus.in_ready);
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  64'(start),        64'd0);
        check({tag, "_busy"},   64'(busy),         64'd0);
        check({tag, "_error"},  64'(error),        64'd0);
        check({tag, "_ready"},  64'(bus.in_ready), 64'd0);
        check({tag, "_we"},     64'(bus.imem_we),  64'd0);
        check({tag, "_addr"},   64'(bus.imem_addr),  64'd0);
        check({tag, "_wdata"},  64'(bus.imem_wdata), 64'd0);
        check({tag, "_sum"},    64'(checksum),     64'd0);
        check({tag, "_count"},  64'(word_count),   64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        load_req     = 1'b0;
        load_len     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Normal 3-word load.
        request(3);
        check("load_busy",  64'(busy),         64'd1);
        check("load_ready", 64'(bus.in_ready), 64'd1);
        send_word(32'h00221020, 0);
        send_word(32'h00221024, 1);
        send_word(32'h10000000, 2);
        check("check_busy",  64'(busy),  64'd1);
        check("check_start", 64'(start), 64'd0);
        send_word(32'h10442044, -1);
        check("norm_start", 64'(start),      64'd1);
        check("norm_error", 64'(error),      64'd0);
        check("norm_busy",  64'(busy),       64'd0);
        check("norm_sum",   64'(checksum),   64'h10442044);
        check("norm_count", 64'(word_count), 64'd3);

        // Reload from RUN with a single word.
        request(1);
        check("reload_start", 64'(start),      64'd0);
        check("reload_busy",  64'(busy),       64'd1);
        check("reload_count", 64'(word_count), 64'd0);
        check("reload_sum",   64'(checksum),   64'd0);
        send_word(32'h0000000A, 0);
        send_word(32'h0000000A, -1);
        check("reload_run", 64'(start),    64'd1);
        check("reload_cs",  64'(checksum), 64'h0000000A);

        // Bad checksum, then retry from ERROR.
        request(3);
        send_word(32'h00221020, 0);
        send_word(32'h00221024, 1);
        send_word(32'h10000000, 2);
        send_word(32'h10442045, -1);
        check("bad_error", 64'(error),      64'd1);
        check("bad_start", 64'(start),      64'd0);
        check("bad_busy",  64'(busy),       64'd0);
        check("bad_sum",   64'(checksum),   64'h10442044);
        check("bad_count", 64'(word_count), 64'd3);
        tick();
        check("bad_hold", 64'(error), 64'd1);
        request(1);
        check("retry_busy",  64'(busy),  64'd1);
        check("retry_error", 64'(error), 64'd0);
        send_word(32'h00000005, 0);
        send_word(32'h00000005, -1);
        check("retry_start", 64'(start), 64'd1);

        // Invalid lengths; in_valid held high must be ignored.
        request(0);
        check("len0_error", 64'(error),        64'd1);
        check("len0_ready", 64'(bus.in_ready), 64'd0);
        check("len0_start", 64'(start),        64'd0);
        request(257);
        check("len257_error", 64'(error), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;

        // Checksum wrap with stalls between the words.
        request(2);
        send_word(32'hFFFFFFFF, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("stall_we", 64'(bus.imem_we), 64'd0);
            tick();
        end
        send_word(32'h00000002, 1);
        check("wrap_sum", 64'(checksum), 64'h00000001);
        send_word(32'h00000001, -1);
        check("wrap_start", 64'(start), 64'd1);
        check("wrap_error", 64'(error), 64'd0);

        // Reset after one of three words.
        request(3);
        send_word(32'h12345678, 0);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0BADF00D;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 64'(bus.in_ready), 64'd0);
            check("idle_count", 64'(word_count),   64'd0);
        end
        bus.in_valid = 1'b0;

        // Full-capacity load: data = address, sum 0..255 = 0x7F80.
        request(256);
        for (int i = 0; i < 256; i++) send_word(DW'(i), i);
        check("max_count", 64'(word_count), 64'd256);
        check("max_sum",   64'(checksum),   64'h7F80);
        send_word(32'h00007F80, -1);
        check("max_start", 64'(start), 64'd1);

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        tests += mon_tests;
        fails += mon_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout got still running required finished");
        $fatal(1, "timeout");
    end

endmodule
